morse_key_sequencer: RTL
========================

# morse_key_sequencer

Controller that sequences the Morse transmit timing counter: it takes one letter code (or a word space), derives mark and space durations from a Morse time unit, and drives the keyed tone-enable line. It sits between the character encoder (which supplies CODE/LEN) and the tone/LED output stage. It replaces free-running counter comparisons with a scheduled, per-element timer restart.

## Interface
- UNIT_TICKS, 12_500_000: clock cycles per Morse time unit (≥1)
- MAX_LEN, 5: maximum elements per letter
- CLK  in  1  system clock; all logic on posedge
- RST  in  1  synchronous reset, active-low: sampled on posedge CLK, RST=0 resets
- START  in  1  request: start sending the presented code; honoured only when BUSY=0
- CODE  in  5  element bits, MSB first: CODE[4] is the first element; 1=dash, 0=dot
- LEN  in  3  number of elements (1..5); 0 = word space; >5 is clamped to 5
- TONE  out  1  key output, 1 during marks
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle pulse when a sequence completes

## Operation
- Reset values: TONE=0, BUSY=0, DONE=0, state IDLE, tick and unit counters 0, latched code/len 0.
- Durations in units: dot mark 1, dash mark 3, inter-element gap 1, letter tail 3 (after the last element), word space 7.
- States:
  - IDLE: waits for START.
  - MARK: TONE=1.
  - GAP: TONE=0, between elements.
  - TAIL: TONE=0, letter gap or word space.
- IDLE + START with LEN≥1: latch CODE and min(LEN,5), element index=0, go to MARK.
- IDLE + START with LEN=0: go to TAIL with a 7-unit length.
- MARK end: if index==len-1, go to TAIL with a 3-unit length; otherwise go to GAP.
- GAP end: index+1, go to MARK.
- TAIL end: go to IDLE, pulse DONE.
- Phase timer: tick counter 0..UNIT_TICKS-1. On wrap, the unit counter increments. The phase ends on the tick-counter wrap that completes the last unit. Both counters clear on every phase entry.
- START while BUSY=1 is ignored; CODE/LEN are don't-care after the accept edge.
- Counter widths: tick counter is $clog2(UNIT_TICKS) bits (min 1); unit counter is 3 bits (max value 7). No overflow is possible.

## Timing
- Accept: START=1 sampled at edge E in IDLE → from E, BUSY=1 and TONE reflects the first phase, with no idle cycle.
- Every phase lasts exactly units×UNIT_TICKS cycles; TONE is a registered output, glitch-free.
- Total busy cycles for a letter = UNIT_TICKS × (Σmark + (len-1) + 3). For a word space the total is 7×UNIT_TICKS.
- DONE=1 and BUSY=0 in the first cycle after TAIL ends.
- START in that same DONE cycle is accepted, so back-to-back letters have no extra gap.
- RST=0 mid-sequence: at the next edge all outputs take their reset values and no DONE is issued. START during reset is ignored.
- UNIT_TICKS=1: each unit is one cycle; all rules above still hold.

## Structure
- Shared package morse_pkg holds:
  - state encoding: IDLE, MARK, GAP, TAIL
  - DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7, MAX_LEN=5
- One sub-module, morse_unit_timer:
  - parameter UNIT_TICKS
  - inputs CLK, RST, CLR, and target unit count
  - output phase_end pulse
  - the sequencer FSM instantiates it

## Test plan
- UNIT_TICKS=4, LEN=2, CODE=5'b01000 ('A') → TONE high 4 cycles, low 4, high 12, low 12; BUSY high 32 cycles; DONE pulses on cycle 33.
- UNIT_TICKS=2, LEN=0 → TONE stays 0; BUSY high 14 cycles; single DONE.
- UNIT_TICKS=3, LEN=7, CODE=5'b11111 → treated as 5 dashes: 5 marks of 9 cycles, 4 gaps of 3 cycles, tail of 9 cycles; BUSY=66 cycles.
- START held high continuously with 'E' (LEN=1, CODE=0), UNIT_TICKS=2 → mark 2, tail 6, DONE. The next letter starts in the DONE cycle; mid-sequence START pulses cause no restart.
- RST=0 for one cycle during the second mark of 'A' → next cycle TONE=0, BUSY=0, DONE=0. A fresh START afterwards produces the full 32-cycle pattern.
- UNIT_TICKS=1, 'A' → pattern 1/1/3/3 cycles, BUSY=8 cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// +----------------------------------------------------------------------+
// | morse_pkg                                                            |
// | Shared state encoding and element durations for the Morse keyer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package morse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      GAP  = 2'd2,
      TAIL = 2'd3
   } state_t;

   localparam logic [2:0] DOT_UNITS        = 3'd1;
   localparam logic [2:0] DASH_UNITS       = 3'd3;
   localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
   localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
   localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;
   localparam logic [2:0] MAX_LEN          = 3'd5;

endpackage

`default_nettype wire

// File: rtl/morse_unit_timer.sv
// +----------------------------------------------------------------------+
// | morse_unit_timer                                                     |
// | Phase timer: counts ticks per unit and flags the last tick of a      |
// | phase lasting 'target' units.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module morse_unit_timer #(
   parameter int UNIT_TICKS = 12_500_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLR,
   input  logic [2:0] target,
   output logic       phase_end
);

   localparam int                  c_TICK_W    = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(UNIT_TICKS - 1);

   logic [c_TICK_W-1:0] r_tick;
   logic [2:0]          r_unit;
   logic                w_wrap;

   assign w_wrap    = (r_tick == c_TICK_LAST);
   assign phase_end = w_wrap && (r_unit == (target - 3'd1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_tick <= '0;
         r_unit <= '0;
      end else if (CLR) begin
         r_tick <= '0;
         r_unit <= '0;
      end else if (w_wrap) begin
         r_tick <= '0;
         r_unit <= r_unit + 3'd1;
      end else begin
         r_tick <= r_tick + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/morse_key_sequencer.sv
// +----------------------------------------------------------------------+
// | morse_key_sequencer                                                  |
// | Sequences marks, gaps and tails of one Morse letter or word space    |
// | and drives the registered key line.                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module morse_key_sequencer #(
   parameter int UNIT_TICKS = 12_500_000,
   parameter int MAX_LEN    = 5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [4:0] CODE,
   input  logic [2:0] LEN,
   output logic       TONE,
   output logic       BUSY,
   output logic       DONE
);

   import morse_pkg::*;

   localparam logic [2:0] c_LEN_CAP = 3'(MAX_LEN);

   state_t     r_state;
   state_t     w_next_state;
   logic [4:0] r_code;
   logic [2:0] r_len;
   logic [2:0] r_idx;
   logic       r_tone;
   logic       r_busy;
   logic       r_done;

   logic       w_load;
   logic       w_advance;
   logic       w_done;
   logic [2:0] w_target;
   logic       w_clr;
   logic       w_phase_end;

   // Timer is held clear while idle so the first phase starts from zero.
   assign w_clr = (r_state == IDLE) || w_phase_end;

   morse_unit_timer #(
      .UNIT_TICKS (UNIT_TICKS)
   ) u_timer (
      .CLK       (CLK),
      .RST       (RST),
      .CLR       (w_clr),
      .target    (w_target),
      .phase_end (w_phase_end)
   );

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_advance    = 1'b0;
      w_done       = 1'b0;
      w_target     = DOT_UNITS;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_load       = 1'b1;
               w_next_state = (LEN == 3'd0) ? TAIL : MARK;
            end
         end
         MARK: begin
            w_target = r_code[4] ? DASH_UNITS : DOT_UNITS;
            if (w_phase_end) begin
               w_next_state = (r_idx == (r_len - 3'd1)) ? TAIL : GAP;
            end
         end
         GAP: begin
            w_target = ELEM_GAP_UNITS;
            if (w_phase_end) begin
               w_advance    = 1'b1;
               w_next_state = MARK;
            end
         end
         TAIL: begin
            // A latched length of zero marks a word space.
            w_target = (r_len == 3'd0) ? WORD_GAP_UNITS : LETTER_GAP_UNITS;
            if (w_phase_end) begin
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= IDLE;
         r_code  <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_tone  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_tone  <= (w_next_state == MARK);
         r_busy  <= (w_next_state != IDLE);
         r_done  <= w_done;
         if (w_load) begin
            r_code <= CODE;
            r_len  <= (LEN > c_LEN_CAP) ? c_LEN_CAP : LEN;
            r_idx  <= '0;
         end else if (w_advance) begin
            r_code <= {r_code[3:0], 1'b0};
            r_idx  <= r_idx + 3'd1;
         end
      end
   end

   assign TONE = r_tone;
   assign BUSY = r_busy;
   assign DONE = r_done;

endmodule

`default_nettype wire
